// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract. Each
// produces one bit per cycle, followed by a single sign-fixup cycle.
// Ports:
//   clk, reset        : clock (rising edge) and synchronous active-high reset
//   start, op, Sign   : request strobe, operation (00 mult, 01 div, 10 mthi,
//                       11 mtlo) and signed/unsigned operand select
//   A, B              : operands (multiplicand/dividend/move source, multiplier/divisor)
//   busy, done        : in-progress flag and one-cycle completion pulse
//   div_by_zero       : sticky divide-by-zero flag, cleared by the next accepted start
//   hi, lo            : result registers
// Optional feature macro: MULDIV_EARLY_EXIT_EN. When defined, a multiply ends as
// soon as the remaining multiplier bits are all zero.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [W2-1:0]    a_q, a_d;       // shifted multiplicand (mult)
  logic [WIDTH-1:0] b_q, b_d;       // remaining multiplier bits / divisor
  logic [W2-1:0]    acc_q, acc_d;   // product, or {remainder, dividend/quotient}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_a_q, neg_a_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (Sign && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
  assign b_mag = (Sign && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;

  // Restoring division step: shift next dividend bit into the partial remainder.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_lt;
  assign div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_lt    = div_diff[WIDTH];

  // Sign fixup of the finished magnitudes.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (W2'(0) - acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? (WIDTH'(0) - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

  logic mul_last;
`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_last = (cnt_q == CNT_LAST) || ((b_q >> 1) == '0);
`else
  assign mul_last = (cnt_q == CNT_LAST);
`endif

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    dz_d      = dz_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          case (op)
            OP_MTHI: begin
              hi_d    = A;
              state_d = S_DONE;
            end
            OP_MTLO: begin
              lo_d    = A;
              state_d = S_DONE;
            end
            default: begin
              a_d       = {{WIDTH{1'b0}}, a_mag};
              b_d       = b_mag;
              acc_d     = (op == OP_DIV) ? {{WIDTH{1'b0}}, a_mag} : '0;
              cnt_d     = '0;
              is_div_d  = (op == OP_DIV);
              neg_res_d = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_a_d   = Sign & A[WIDTH-1];
              dz_d      = (B == '0);
              state_d   = (op == OP_MULT) ? S_MUL : S_DIV;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {(div_lt ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_lt};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // Divide-by-zero leaves |A| in the remainder, so hi becomes A as issued.
          lo_d  = dz_q ? '1 : quo_fix;
          hi_d  = rem_fix;
          dbz_d = dz_q;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
